// File: rtl/ia_issue_ctrl.sv
// Control side of the ia_loader handshake: credit-limited access grants, send triggers,
// and tile completion tracking. Optional send watchdog is enabled with IA_ISSUE_WDOG_EN.
module ia_issue_ctrl #(
  parameter int unsigned REG_WIDTH   = 32,
  parameter int unsigned MAX_OUTST   = 2,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [REG_WIDTH-1:0] num_tiles,
  input  logic                 array_ready,
  input  logic                 load_ia_req,
  output logic                 load_ia_granted,
  input  logic                 ia_data_valid,
  output logic                 send_ia_trigger,
  input  logic                 ia_sending_done,
  input  logic                 ia_calc_done,
  output logic                 busy,
  output logic                 done,
  output logic [REG_WIDTH-1:0] tiles_sent,
  output logic                 err
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTST);

  if (MAX_OUTST < 1 || WDOG_CYCLES < 1) begin : g_param_check
    $error("ia_issue_ctrl: MAX_OUTST and WDOG_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SEND,
    FIN
  } state_t;

  state_t               state;
  logic [REG_WIDTH-1:0] num_lat;
  logic [REG_WIDTH-1:0] grants;
  logic [REG_WIDTH-1:0] tiles_inc;
  logic [OW-1:0]        outst;
  logic                 grant_cond;
  logic                 trig_cond;
  logic                 done_evt;

`ifdef IA_ISSUE_WDOG_EN
  localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);
  logic [WW-1:0] wdog_cnt;
`endif

  always_comb begin
    grant_cond = 1'b0;
    trig_cond  = 1'b0;
    done_evt   = 1'b0;
    tiles_inc  = tiles_sent + REG_WIDTH'(1);
    // The !load_ia_granted term keeps grants at least one idle cycle apart.
    if ((state == RUN || state == SEND) && load_ia_req && (outst < MAX_O) &&
        (grants < num_lat) && !load_ia_granted)
      grant_cond = 1'b1;
    if (state == RUN && ia_data_valid && array_ready && (outst != '0))
      trig_cond = 1'b1;
    if (state == SEND && ia_sending_done)
      done_evt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      num_lat         <= '0;
      grants          <= '0;
      outst           <= '0;
      tiles_sent      <= '0;
      err             <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      load_ia_granted <= 1'b0;
      send_ia_trigger <= 1'b0;
`ifdef IA_ISSUE_WDOG_EN
      wdog_cnt        <= '0;
`endif
    end else begin
      load_ia_granted <= grant_cond;
      send_ia_trigger <= 1'b0;
      done            <= 1'b0;

      if (grant_cond)
        grants <= grants + REG_WIDTH'(1);

      // A grant and a completion in the same cycle cancel out.
      if (grant_cond && !done_evt)
        outst <= outst + OW'(1);
      else if (!grant_cond && done_evt)
        outst <= outst - OW'(1);

      if (ia_sending_done && state != SEND)
        err <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            num_lat    <= num_tiles;
            tiles_sent <= '0;
            err        <= 1'b0;
            grants     <= '0;
            outst      <= '0;
            busy       <= 1'b1;
            state      <= (num_tiles == '0) ? FIN : RUN;
          end
        end

        RUN: begin
          if (trig_cond) begin
            send_ia_trigger <= 1'b1;
            state           <= SEND;
`ifdef IA_ISSUE_WDOG_EN
            wdog_cnt        <= '0;
`endif
          end
        end

        SEND: begin
          if (ia_sending_done) begin
            tiles_sent <= tiles_inc;
            if (tiles_inc == num_lat) begin
              if (!ia_calc_done)
                err <= 1'b1;
              state <= FIN;
            end else begin
              if (ia_calc_done)
                err <= 1'b1;
              state <= RUN;
            end
          end
`ifdef IA_ISSUE_WDOG_EN
          else if (wdog_cnt == WDOG_LAST) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + WW'(1);
          end
`endif
        end

        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ia_issue_ctrl.sv
// Directed bench for ia_issue_ctrl with a job scoreboard popped on every done pulse.
module tb_ia_issue_ctrl;

  localparam int unsigned RW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [RW-1:0] num_tiles;
  logic          array_ready;
  logic          load_ia_req;
  logic          load_ia_granted;
  logic          ia_data_valid;
  logic          send_ia_trigger;
  logic          ia_sending_done;
  logic          ia_calc_done;
  logic          busy;
  logic          done;
  logic [RW-1:0] tiles_sent;
  logic          err;

  ia_issue_ctrl #(
    .REG_WIDTH  (RW),
    .MAX_OUTST  (2),
    .WDOG_CYCLES(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_tiles      (num_tiles),
    .array_ready    (array_ready),
    .load_ia_req    (load_ia_req),
    .load_ia_granted(load_ia_granted),
    .ia_data_valid  (ia_data_valid),
    .send_ia_trigger(send_ia_trigger),
    .ia_sending_done(ia_sending_done),
    .ia_calc_done   (ia_calc_done),
    .busy           (busy),
    .done           (done),
    .tiles_sent     (tiles_sent),
    .err            (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned tiles;
    int unsigned err;
    int unsigned grants;
    int unsigned trigs;
  } exp_t;

  exp_t sb[$];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned mon_g = 0;
  int unsigned mon_t = 0;
  int unsigned rcnt  = 0;
  logic        prev_g = 1'b0;

  // loader model controls, written only by the main sequence
  logic        resp_en = 1'b0;
  int unsigned resp_n  = 0;
  int unsigned bad_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int unsigned t, input int unsigned e,
                          input int unsigned g, input int unsigned tr);
    exp_t x;
    x.tiles  = t;
    x.err    = e;
    x.grants = g;
    x.trigs  = tr;
    sb.push_back(x);
  endtask

  task automatic start_job(input int unsigned n, input int unsigned bad);
    resp_n    = n;
    bad_idx   = bad;
    num_tiles = n;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_done"}, done, 1);
  endtask

  // Loader model: completes each triggered tile 4 cycles later.
  initial begin
    ia_sending_done = 1'b0;
    ia_calc_done    = 1'b0;
    forever begin
      @(negedge clk);
      ia_sending_done = 1'b0;
      ia_calc_done    = 1'b0;
      if (resp_en && send_ia_trigger && !rst) begin
        repeat (3) @(negedge clk);
        rcnt++;
        ia_sending_done = 1'b1;
        ia_calc_done    = (rcnt == resp_n) ^ (rcnt == bad_idx);
        if (rcnt == resp_n) rcnt = 0;
      end
    end
  end

  // Monitor: grant/trigger counting and scoreboard pop on done.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_g  = 0;
        mon_t  = 0;
        prev_g = 1'b0;
      end else begin
        if (load_ia_granted) begin
          check("no_b2b_grant", prev_g, 0);
          mon_g++;
        end
        prev_g = load_ia_granted;
        if (send_ia_trigger) mon_t++;
        if (done) begin
          check("done_expected", (sb.size() != 0), 1);
          if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("sb_tiles_sent", tiles_sent, e.tiles);
            check("sb_err", err, e.err);
            check("sb_grants", mon_g, e.grants);
            check("sb_triggers", mon_t, e.trigs);
          end
          mon_g = 0;
          mon_t = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    num_tiles   = '0;
    array_ready = 1'b0;
    load_ia_req = 1'b0;
    ia_data_valid = 1'b0;

    // 1: reset values, then an empty job
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_grant", load_ia_granted, 0);
    check("rst_trigger", send_ia_trigger, 0);
    check("rst_tiles", tiles_sent, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);
    push_exp(0, 0, 0, 0);
    start_job(0, 0);
    check("t1_busy", busy, 1);
    check("t1_no_early_done", done, 0);
    @(negedge clk);
    check("t1_done", done, 1);
    check("t1_busy_low", busy, 0);
    @(negedge clk);

    // 2: three tiles, everything ready
    load_ia_req   = 1'b1;
    ia_data_valid = 1'b1;
    array_ready   = 1'b1;
    resp_en       = 1'b1;
    push_exp(3, 0, 3, 3);
    start_job(3, 0);
    wait_done("t2", 200);
    check("t2_tiles", tiles_sent, 3);
    check("t2_err", err, 0);
    @(negedge clk);

    // 3: array stalled -> credit limit caps grants at 2
    array_ready = 1'b0;
    push_exp(4, 0, 4, 4);
    start_job(4, 0);
    repeat (20) @(negedge clk);
    check("t3_stall_grants", mon_g, 2);
    check("t3_stall_trigs", mon_t, 0);
    check("t3_busy", busy, 1);
    array_ready = 1'b1;
    wait_done("t3", 300);
    @(negedge clk);

    // 4: calc_done on the wrong tile -> sticky err, cleared by next start
    push_exp(2, 1, 2, 2);
    start_job(2, 1);
    wait_done("t4", 200);
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("t4_err_sticky", err, 1);
    push_exp(1, 0, 1, 1);
    start_job(1, 0);
    check("t4_err_cleared", err, 0);
    wait_done("t4b", 200);
    @(negedge clk);

    // 5: reset while in SEND with two tiles outstanding
    resp_en = 1'b0;
    start_job(3, 0);
    begin
      int i = 0;
      while (mon_g < 2 && i < 20) begin
        @(negedge clk);
        i++;
      end
    end
    check("t5_two_grants", mon_g, 2);
    check("t5_outst", dut.outst, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_outst_clr", dut.outst, 0);
    check("t5_grant_drop", load_ia_granted, 0);
    check("t5_trig_drop", send_ia_trigger, 0);
    check("t5_tiles", tiles_sent, 0);
    resp_en = 1'b1;
    push_exp(1, 0, 1, 1);
    start_job(1, 0);
    wait_done("t5", 200);
    @(negedge clk);

    // 6: no sending_done after a trigger
    resp_en = 1'b0;
`ifdef IA_ISSUE_WDOG_EN
    push_exp(0, 1, 1, 1);
`endif
    start_job(1, 0);
    begin
      int i = 0;
      while (!send_ia_trigger && i < 20) begin
        @(negedge clk);
        i++;
      end
    end
    check("t6_trigger", send_ia_trigger, 1);
`ifdef IA_ISSUE_WDOG_EN
    repeat (15) @(negedge clk);
    check("t6_no_early_abort", done, 0);
    @(negedge clk);
    check("t6_wdog_done", done, 1);
    check("t6_wdog_err", err, 1);
    @(negedge clk);
    check("t6_idle", busy, 0);
`else
    repeat (40) @(negedge clk);
    check("t6_busy_held", busy, 1);
    check("t6_no_done", done, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
